fifo_pop_stream: RTL and testbench
==================================

FIFO_POP_STREAM -- requirements
Module: fifo_pop_stream

Interface
REQ-001 Parameter DATA_W, default 8: width of one FIFO word and one stream beat.
REQ-002 Parameter CNT_W, default 16: width of the delivered-beat counter.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 fifo_empty  in  1  empty flag of the upstream synchronous FIFO.
REQ-006 fifo_rd_en  out  1  pop request to upstream FIFO; FIFO presents data registered one cycle later.
REQ-007 fifo_dout  in  DATA_W  upstream FIFO registered read data.
REQ-008 flush  in  1  synchronous discard of all buffered and in-flight data.
REQ-009 out_valid  out  1  stream beat available.
REQ-010 out_ready  in  1  downstream accepts beat.
REQ-011 out_data  out  DATA_W  stream beat payload.
REQ-012 level  out  2  entries held in skid buffer (0..2).
REQ-013 beat_cnt  out  CNT_W  count of accepted beats (out_valid && out_ready), wraps modulo 2^CNT_W.

Function
REQ-014 Beat transfer occurs in any cycle with out_valid=1 and out_ready=1.
REQ-015 inflight flag shall set on each cycle fifo_rd_en=1 and clear the following cycle; captured data = fifo_dout in the cycle after the pop.
REQ-016 fifo_rd_en shall be 1 iff fifo_empty=0, flush=0, and (level + inflight - transfer) < 2.
REQ-017 fifo_rd_en shall never assert while fifo_empty=1.
REQ-018 Skid buffer states EMPTY, ONE, TWO; EMPTY->ONE on capture; ONE->TWO on capture without transfer; TWO->ONE on transfer; ONE->EMPTY on transfer without capture; capture+transfer in ONE stays ONE.
REQ-019 out_valid shall equal (level != 0); out_data shall be the oldest entry and stay stable while out_valid=1 and out_ready=0.
REQ-020 Order of beats shall equal FIFO pop order; no loss, no duplication.
REQ-021 Latency: pop in cycle t -> out_valid=1 in cycle t+2 when buffer was EMPTY.
REQ-022 Throughput: with fifo_empty=0 and out_ready=1 continuously, one beat per cycle after initial latency.
REQ-023 flush=1: level->0 next cycle, inflight cleared, any data returning next cycle dropped, no transfer counted in flush cycle, beat_cnt unchanged.
REQ-024 beat_cnt increments by 1 per transfer; all-ones + 1 -> 0.

Reset
REQ-025 On rst=0: fifo_rd_en=0, out_valid=0, out_data=0, level=0, inflight=0, beat_cnt=0, state EMPTY, immediately and asynchronously.
REQ-026 Reset mid-operation shall discard buffered/in-flight data; first pop earliest in first clock after rst deasserts.

Configuration
REQ-027 Macro FIFO_POP_STREAM_PARITY_EN defined: output out_par (1 bit) = even parity (XOR) of out_data, valid with out_valid, 0 in reset.
REQ-028 Macro undefined: out_par port absent; all other behaviour identical.

Structure
REQ-029 Shared package fifo_stream_pkg shall hold DATA_W/CNT_W defaults and the skid-state enumeration (EMPTY, ONE, TWO).
REQ-030 Sub-module fifo_pop_skid shall implement the 2-entry buffer (push, pop, level, head data); top holds pop control, inflight flag, counter, optional parity.

Verification
REQ-031 FIFO holds 0x11,0x22,0x33, out_ready=1 -> pops at t,t+1,t+2; out_data 0x11,0x22,0x33 at t+2..t+4; beat_cnt=3.
REQ-032 4 bytes queued, out_ready=0 -> exactly 2 pops, level=2, fifo_rd_en stays 0, out_data holds first byte; release ready -> remaining bytes in order.
REQ-033 fifo_empty toggling each cycle with random out_ready over 1000 bytes -> scoreboard order intact, fifo_rd_en never 1 when empty.
REQ-034 flush asserted one cycle after a pop with level=1 -> next cycle level=0, out_valid=0, returned byte never appears, beat_cnt unchanged.
REQ-035 CNT_W=4, 17 transfers -> beat_cnt=1.
REQ-036 rst=0 asserted mid-burst between edges -> outputs zero immediately; with PARITY_EN, out_data=0x07 -> out_par=1.

Source files
------------

// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the FIFO-pop-to-stream slice: width defaults and
// the skid buffer state encoding.
package fifo_stream_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/fifo_pop_stream_if.sv
// Handshake bundle between the upstream FIFO, the pop/stream block and the
// downstream consumer. master = the fifo_pop_stream block.
// Optional: FIFO_POP_STREAM_PARITY_EN adds out_par (XOR parity of out_data).
interface fifo_pop_stream_if #(
  parameter int DATA_W = fifo_stream_pkg::DEF_DATA_W
);

  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

`ifdef FIFO_POP_STREAM_PARITY_EN
  logic              out_par;

  modport master (
    input  fifo_empty, fifo_dout, out_ready,
    output fifo_rd_en, out_valid, out_data, out_par
  );

  modport slave (
    output fifo_empty, fifo_dout, out_ready,
    input  fifo_rd_en, out_valid, out_data, out_par
  );
`else
  modport master (
    input  fifo_empty, fifo_dout, out_ready,
    output fifo_rd_en, out_valid, out_data
  );

  modport slave (
    output fifo_empty, fifo_dout, out_ready,
    input  fifo_rd_en, out_valid, out_data
  );
`endif

endinterface

// File: rtl/fifo_pop_skid.sv
// Two-entry skid buffer: push captures returning FIFO data, pop hands the
// head entry to the stream. Head is always the oldest entry.
module fifo_pop_skid
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [1:0]        o_level,
  output logic [DATA_W-1:0] o_head
);

  skid_state_t       r_state;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic [1:0]        r_level;
  logic              r_valid;

  // Buffer FSM with registered level/valid/head outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= 2'd0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_state <= EMPTY;
      r_level <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (i_push) begin
            r_head  <= i_push_data;
            r_state <= ONE;
            r_level <= 2'd1;
            r_valid <= 1'b1;
          end
        end
        ONE: begin
          if (i_push && !i_pop) begin
            r_tail  <= i_push_data;
            r_state <= TWO;
            r_level <= 2'd2;
          end else if (i_push && i_pop) begin
            r_head <= i_push_data;
          end else if (i_pop) begin
            r_state <= EMPTY;
            r_level <= 2'd0;
            r_valid <= 1'b0;
          end
        end
        TWO: begin
          if (i_pop) begin
            r_head <= r_tail;
            if (i_push) begin
              r_tail <= i_push_data;
            end else begin
              r_state <= ONE;
              r_level <= 2'd1;
            end
          end
        end
        default: begin
          r_state <= EMPTY;
          r_level <= 2'd0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_level = r_level;
  assign o_head  = r_head;

endmodule

// File: rtl/fifo_pop_stream.sv
// Converts a registered-read synchronous FIFO into a valid/ready stream.
// Pop control tracks the one in-flight read so the 2-entry skid buffer can
// never overflow, giving one beat per cycle under continuous ready.
// Optional: FIFO_POP_STREAM_PARITY_EN adds bus.out_par.
module fifo_pop_stream
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  fifo_pop_stream_if.master bus,
  output logic [1:0]       level,
  output logic [CNT_W-1:0] beat_cnt
);

  logic              r_inflight;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic              w_valid;
  logic [1:0]        w_level;
  logic [DATA_W-1:0] w_head;
  logic              w_transfer;
  logic              w_capture;
  logic              w_rd_en;
  logic [2:0]        w_occ;

  assign w_transfer = w_valid & bus.out_ready & ~flush;
  assign w_capture  = r_inflight & ~flush;
  assign w_occ      = {1'b0, w_level} + {2'b00, r_inflight};
  // level + inflight - transfer < 2, rearranged to avoid going negative;
  // rst gating keeps the pop request low during asynchronous reset.
  assign w_rd_en    = rst & ~bus.fifo_empty & ~flush &
                      (w_occ < (3'd2 + {2'b00, w_transfer}));

  // In-flight flag: set by each pop, data captured the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
    end
  end

  // Delivered-beat counter, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat_cnt <= '0;
    end else if (w_transfer) begin
      r_beat_cnt <= r_beat_cnt + CNT_W'(1);
    end
  end

  fifo_pop_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_capture),
    .i_push_data (bus.fifo_dout),
    .i_pop       (w_transfer),
    .i_flush     (flush),
    .o_valid     (w_valid),
    .o_level     (w_level),
    .o_head      (w_head)
  );

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.out_valid  = w_valid;
  assign bus.out_data   = w_head;
  assign level          = w_level;
  assign beat_cnt       = r_beat_cnt;

`ifdef FIFO_POP_STREAM_PARITY_EN
  assign bus.out_par = ^w_head;
`endif

endmodule

// File: tb/tb_fifo_pop_stream.sv
// Directed bench for fifo_pop_stream with a behavioural registered-read FIFO.
module tb_fifo_pop_stream;
  import fifo_stream_pkg::*;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [1:0]    level;
  logic [CW-1:0] beat_cnt;

  int checks    = 0;
  int failures  = 0;
  int exp_total = 0;
  int pop_cnt   = 0;
  logic [7:0] src_q[$];

  fifo_pop_stream_if #(.DATA_W(DW)) bus ();

  fifo_pop_stream #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .level    (level),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: data appears on fifo_dout the cycle after a pop.
  always @(posedge clk) begin
    if (rst && bus.fifo_rd_en && src_q.size() > 0) begin
      bus.fifo_dout <= src_q.pop_front();
      pop_cnt++;
    end
  end

  task automatic drive(input logic rdy, input logic hold, input logic fl);
    @(negedge clk);
    bus.out_ready  = rdy;
    bus.fifo_empty = hold || (src_q.size() == 0);
    flush          = fl;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; flush = 1'b0; bus.out_ready = 1'b0; bus.fifo_empty = 1'b1;
    src_q.delete();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%0b exp=0", bus.fifo_rd_en); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%0h exp=0", bus.out_data); end
    checks++; if (level !== 2'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (beat_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", beat_cnt); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic;
    logic       erd[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       ev[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] ed[6]  = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    src_q = '{8'h11, 8'h22, 8'h33};
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 1'b0);
      checks++; if (bus.fifo_rd_en !== erd[c]) begin failures++; $display("FAIL basic_rd_en c=%0d got=%0b exp=%0b", c, bus.fifo_rd_en, erd[c]); end
      checks++; if (bus.out_valid !== ev[c]) begin failures++; $display("FAIL basic_valid c=%0d got=%0b exp=%0b", c, bus.out_valid, ev[c]); end
      if (ev[c]) begin
        checks++; if (bus.out_data !== ed[c]) begin failures++; $display("FAIL basic_data c=%0d got=%0h exp=%0h", c, bus.out_data, ed[c]); end
`ifdef FIFO_POP_STREAM_PARITY_EN
        checks++; if (bus.out_par !== ^ed[c]) begin failures++; $display("FAIL basic_par c=%0d got=%0b exp=%0b", c, bus.out_par, ^ed[c]); end
`endif
      end
    end
    exp_total = 3;
    checks++; if (beat_cnt !== exp_total[CW-1:0]) begin failures++; $display("FAIL basic_cnt got=%0d exp=%0d", beat_cnt, exp_total[CW-1:0]); end
  endtask

  task automatic test_backpressure;
    logic       erd[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0] elv[7] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
    int k = 0;
    pop_cnt = 0;
    src_q = '{8'h41, 8'h42, 8'h43, 8'h44};
    for (int c = 0; c < 7; c++) begin
      drive(1'b0, 1'b0, 1'b0);
      checks++; if (bus.fifo_rd_en !== erd[c]) begin failures++; $display("FAIL bp_rd_en c=%0d got=%0b exp=%0b", c, bus.fifo_rd_en, erd[c]); end
      checks++; if (level !== elv[c]) begin failures++; $display("FAIL bp_level c=%0d got=%0d exp=%0d", c, level, elv[c]); end
      if (c >= 2) begin
        checks++; if (bus.out_data !== 8'h41) begin failures++; $display("FAIL bp_hold c=%0d got=%0h exp=41", c, bus.out_data); end
      end
    end
    checks++; if (pop_cnt !== 2) begin failures++; $display("FAIL bp_pops got=%0d exp=2", pop_cnt); end
    for (int c = 0; c < 20 && k < 4; c++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (bus.out_valid && bus.out_ready) begin
        checks++; if (bus.out_data !== 8'h41 + 8'(k)) begin failures++; $display("FAIL bp_order k=%0d got=%0h exp=%0h", k, bus.out_data, 8'h41 + 8'(k)); end
        k++;
      end
    end
    checks++; if (k !== 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", k); end
    drive(1'b0, 1'b0, 1'b0);
    exp_total = 7;
    checks++; if (beat_cnt !== exp_total[CW-1:0]) begin failures++; $display("FAIL bp_cnt got=%0d exp=%0d", beat_cnt, exp_total[CW-1:0]); end
  endtask

  task automatic test_flush;
    int k = 0;
    src_q = '{8'h55, 8'h66};
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (bus.fifo_rd_en !== 1'b1) begin failures++; $display("FAIL fl_pop0 got=%0b exp=1", bus.fifo_rd_en); end
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (bus.fifo_rd_en !== 1'b1) begin failures++; $display("FAIL fl_pop1 got=%0b exp=1", bus.fifo_rd_en); end
    drive(1'b1, 1'b0, 1'b1);
    checks++; if (level !== 2'd1) begin failures++; $display("FAIL fl_pre_level got=%0d exp=1", level); end
    checks++; if (bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL fl_rd_en got=%0b exp=0", bus.fifo_rd_en); end
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (level !== 2'd0) begin failures++; $display("FAIL fl_level got=%0d exp=0", level); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL fl_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (beat_cnt !== exp_total[CW-1:0]) begin failures++; $display("FAIL fl_cnt got=%0d exp=%0d", beat_cnt, exp_total[CW-1:0]); end
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL fl_dropped got=%0b exp=0", bus.out_valid); end
    src_q = '{8'h77};
    for (int c = 0; c < 10 && k < 1; c++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (bus.out_valid && bus.out_ready) begin
        checks++; if (bus.out_data !== 8'h77) begin failures++; $display("FAIL fl_next got=%0h exp=77", bus.out_data); end
        k++;
      end
    end
    checks++; if (k !== 1) begin failures++; $display("FAIL fl_next_seen got=%0d exp=1", k); end
    drive(1'b0, 1'b0, 1'b0);
    exp_total = 8;
    checks++; if (beat_cnt !== exp_total[CW-1:0]) begin failures++; $display("FAIL fl_cnt2 got=%0d exp=%0d", beat_cnt, exp_total[CW-1:0]); end
  endtask

  task automatic test_back_to_back;
    src_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    for (int c = 0; c < 9; c++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (c >= 2 && c <= 7) begin
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid c=%0d got=%0b exp=1", c, bus.out_valid); end
        checks++; if (bus.out_data !== 8'hA0 + 8'(c - 2)) begin failures++; $display("FAIL b2b_data c=%0d got=%0h exp=%0h", c, bus.out_data, 8'hA0 + 8'(c - 2)); end
      end else begin
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle c=%0d got=%0b exp=0", c, bus.out_valid); end
      end
    end
    exp_total = 14;
    checks++; if (beat_cnt !== exp_total[CW-1:0]) begin failures++; $display("FAIL b2b_cnt got=%0d exp=%0d", beat_cnt, exp_total[CW-1:0]); end
  endtask

  task automatic test_random;
    int rx = 0;
    int viol = 0;
    logic [7:0] exp_b;
    for (int i = 0; i < 1000; i++) src_q.push_back(8'((i * 7 + 3) & 8'hFF));
    for (int c = 0; c < 8000 && rx < 1000; c++) begin
      drive(1'($urandom_range(0, 1)), 1'(c & 1), 1'b0);
      if (bus.fifo_rd_en && bus.fifo_empty) viol++;
      if (bus.out_valid && bus.out_ready) begin
        exp_b = 8'((rx * 7 + 3) & 8'hFF);
        checks++; if (bus.out_data !== exp_b) begin failures++; $display("FAIL rnd_data n=%0d got=%0h exp=%0h", rx, bus.out_data, exp_b); end
        rx++;
      end
    end
    checks++; if (rx !== 1000) begin failures++; $display("FAIL rnd_count got=%0d exp=1000", rx); end
    checks++; if (viol !== 0) begin failures++; $display("FAIL rnd_pop_empty got=%0d exp=0", viol); end
    drive(1'b0, 1'b0, 1'b0);
    exp_total = 1014;
    checks++; if (beat_cnt !== exp_total[CW-1:0]) begin failures++; $display("FAIL rnd_cnt got=%0d exp=%0d", beat_cnt, exp_total[CW-1:0]); end
  endtask

  task automatic test_reset_mid;
    src_q = '{8'h07, 8'h08, 8'h09, 8'h0A};
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (bus.out_data !== 8'h07) begin failures++; $display("FAIL rm_pre_data got=%0h exp=07", bus.out_data); end
`ifdef FIFO_POP_STREAM_PARITY_EN
    checks++; if (bus.out_par !== 1'b1) begin failures++; $display("FAIL rm_par got=%0b exp=1", bus.out_par); end
`endif
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL rm_data got=%0h exp=0", bus.out_data); end
    checks++; if (level !== 2'd0) begin failures++; $display("FAIL rm_level got=%0d exp=0", level); end
    checks++; if (beat_cnt !== '0) begin failures++; $display("FAIL rm_cnt got=%0d exp=0", beat_cnt); end
    checks++; if (bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL rm_rd_en got=%0b exp=0", bus.fifo_rd_en); end
`ifdef FIFO_POP_STREAM_PARITY_EN
    checks++; if (bus.out_par !== 1'b0) begin failures++; $display("FAIL rm_par0 got=%0b exp=0", bus.out_par); end
`endif
    @(negedge clk);
    src_q.delete();
    @(negedge clk);
    rst = 1'b1;
    exp_total = 0;
  endtask

  task automatic test_wrap;
    int k = 0;
    for (int i = 0; i < 17; i++) src_q.push_back(8'(i));
    for (int c = 0; c < 40 && k < 17; c++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (bus.out_valid && bus.out_ready) k++;
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (k !== 17) begin failures++; $display("FAIL wrap_count got=%0d exp=17", k); end
    checks++; if (beat_cnt !== 4'd1) begin failures++; $display("FAIL wrap_cnt got=%0d exp=1", beat_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
